// File: rtl/eth_pr_pkg.sv
// Shared types and constants for the Ethernet packet-routing slice:
// the tagged beat layout and the 14-bit match result.
package eth_pr_pkg;

  localparam int TAG_W     = 10;
  localparam int IFACE_W   = 2;
  localparam int MAC_W     = 48;
  localparam int NUM_IFACE = 4;
  localparam int DATA_W    = 64;
  localparam int BEAT_W    = TAG_W + DATA_W;

  typedef struct packed {
    logic [IFACE_W-1:0] out_iface;
    logic [IFACE_W-1:0] in_iface;
    logic [TAG_W-1:0]   tag;
  } match_result_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } tagged_beat_t;

endpackage

// File: rtl/header_match_dispatch_fifo.sv
// Synchronous FIFO of match results; full/empty derive from an occupancy count.
module match_result_fifo
  import eth_pr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  match_result_t i_push_data,
  input  logic          i_pop,
  output match_result_t o_pop_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  match_result_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Storage array, written on push only
  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1'b1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/header_match_dispatch.sv
// Header lookup and round-robin dispatch of match results for four tagged streams.
// Optional per-interface statistics counters are built when HDR_MATCH_STATS_EN is defined.
module header_match_dispatch
  import eth_pr_pkg::*;
#(
  parameter int NUM_ENTRIES       = 8,
  parameter int RESULT_FIFO_DEPTH = 4,
  parameter int DEFAULT_PORT      = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [BEAT_W-1:0]              pkt_data  [NUM_IFACE-1:0],
  input  logic [NUM_IFACE-1:0]           pkt_valid,
  input  logic [NUM_IFACE-1:0]           pkt_sop,
  input  logic [NUM_IFACE-1:0]           pkt_eop,
  output logic [NUM_IFACE-1:0]           pkt_ready,
  output logic [13:0]                    match_data,
  output logic                           match_valid,
  input  logic                           match_ready,
  input  logic                           cfg_wr,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_addr,
  input  logic                           cfg_en,
  input  logic [MAC_W-1:0]               cfg_mac,
  input  logic [IFACE_W-1:0]             cfg_port,
  output logic [31:0]                    stat_hit  [NUM_IFACE-1:0],
  output logic [31:0]                    stat_miss [NUM_IFACE-1:0],
  output logic [31:0]                    stat_err  [NUM_IFACE-1:0]
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  logic [MAC_W-1:0]       r_tbl_mac  [NUM_ENTRIES];
  logic [IFACE_W-1:0]     r_tbl_port [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_tbl_en;

  logic [0:0]             r_state    [NUM_IFACE];
  logic [IFACE_W-1:0]     r_cap_port [NUM_IFACE];
  logic [IFACE_W-1:0]     r_rr_ptr;
  logic [IFACE_W-1:0]     r_lock_idx;
  logic                   r_locked;

  tagged_beat_t           w_beat      [NUM_IFACE];
  logic [IFACE_W-1:0]     w_lk_port   [NUM_IFACE];
  match_result_t          w_push_data [NUM_IFACE];
  match_result_t          w_pop_data  [NUM_IFACE];
  logic [IFACE_W-1:0]     w_cand      [NUM_IFACE];
  logic [NUM_IFACE-1:0]   w_acc, w_lookup, w_hit, w_err, w_push, w_pop, w_full, w_empty;
  logic [IFACE_W-1:0]     w_rr_grant;
  logic [IFACE_W-1:0]     w_grant;
  logic                   w_handshake;
  logic                   w_unused_low;

  // Table valid bits; only these need clearing on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tbl_en <= '0;
    end else if (cfg_wr) begin
      r_tbl_en[cfg_addr] <= cfg_en;
    end
  end

  // Table payload
  always_ff @(posedge clock) begin
    if (cfg_wr) begin
      r_tbl_mac[cfg_addr]  <= cfg_mac;
      r_tbl_port[cfg_addr] <= cfg_port;
    end
  end

  // Destination-MAC lookup; scanning downward lets the lowest matching index win
  always_comb begin
    w_unused_low = 1'b0;
    for (int i = 0; i < NUM_IFACE; i++) begin
      w_beat[i]    = tagged_beat_t'(pkt_data[i]);
      w_unused_low = w_unused_low ^ (^w_beat[i].data[15:0]);
      w_hit[i]     = 1'b0;
      w_lk_port[i] = IFACE_W'(DEFAULT_PORT);
      for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
        if (r_tbl_en[e] && (r_tbl_mac[e] == w_beat[i].data[DATA_W-1 -: MAC_W])) begin
          w_hit[i]     = 1'b1;
          w_lk_port[i] = r_tbl_port[e];
        end else begin
          w_hit[i]     = w_hit[i];
          w_lk_port[i] = w_lk_port[i];
        end
      end
    end
  end

  // Per-interface beat acceptance, push and protocol-error decode
  always_comb begin
    for (int i = 0; i < NUM_IFACE; i++) begin
      w_acc[i]    = pkt_valid[i] && !w_full[i];
      w_lookup[i] = w_acc[i] && pkt_sop[i];
      w_push[i]   = w_acc[i] && pkt_eop[i] && (pkt_sop[i] || (r_state[i] == ST_IN_PKT));
      w_err[i]    = w_acc[i] && (pkt_sop[i] ? (r_state[i] == ST_IN_PKT)
                                            : (pkt_eop[i] && (r_state[i] == ST_IDLE)));
      w_push_data[i].out_iface = pkt_sop[i] ? w_lk_port[i] : r_cap_port[i];
      w_push_data[i].in_iface  = IFACE_W'(i);
      w_push_data[i].tag       = w_beat[i].tag;
    end
  end

  assign pkt_ready = ~w_full;

  // Packet framing FSM per interface
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_IFACE; i++) begin
      if (reset) begin
        r_state[i]    <= ST_IDLE;
        r_cap_port[i] <= '0;
      end else if (w_lookup[i]) begin
        r_cap_port[i] <= w_lk_port[i];
        r_state[i]    <= pkt_eop[i] ? ST_IDLE : ST_IN_PKT;
      end else if (w_acc[i] && pkt_eop[i]) begin
        r_state[i]    <= ST_IDLE;
      end
    end
  end

  for (genvar g = 0; g < NUM_IFACE; g++) begin : g_fifo
    match_result_fifo #(.DEPTH(RESULT_FIFO_DEPTH)) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .i_push      (w_push[g]),
      .i_push_data (w_push_data[g]),
      .i_pop       (w_pop[g]),
      .o_pop_data  (w_pop_data[g]),
      .o_full      (w_full[g]),
      .o_empty     (w_empty[g])
    );
  end

  // Round-robin grant; a stalled grant is held so match_data cannot change under it
  always_comb begin
    w_rr_grant = r_rr_ptr;
    for (int k = NUM_IFACE - 1; k >= 0; k--) begin
      w_cand[k]  = r_rr_ptr + IFACE_W'(k);
      w_rr_grant = w_empty[w_cand[k]] ? w_rr_grant : w_cand[k];
    end
    w_grant     = r_locked ? r_lock_idx : w_rr_grant;
    match_valid = |(~w_empty);
    match_data  = w_pop_data[w_grant];
    w_handshake = match_valid && match_ready;
    for (int k = 0; k < NUM_IFACE; k++) begin
      w_pop[k] = w_handshake && (w_grant == IFACE_W'(k));
    end
  end

  // Pointer advance and grant lock
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_handshake) begin
      r_rr_ptr   <= w_grant + IFACE_W'(1'b1);
      r_locked   <= 1'b0;
    end else if (match_valid) begin
      r_locked   <= 1'b1;
      r_lock_idx <= w_grant;
    end
  end

`ifdef HDR_MATCH_STATS_EN
  logic [31:0] r_hit  [NUM_IFACE-1:0];
  logic [31:0] r_miss [NUM_IFACE-1:0];
  logic [31:0] r_err  [NUM_IFACE-1:0];

  // Wrapping per-interface event counters
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_IFACE; i++) begin
      if (reset) begin
        r_hit[i]  <= 32'd0;
        r_miss[i] <= 32'd0;
        r_err[i]  <= 32'd0;
      end else begin
        if (w_lookup[i] && w_hit[i])  r_hit[i]  <= r_hit[i] + 32'd1;
        if (w_lookup[i] && !w_hit[i]) r_miss[i] <= r_miss[i] + 32'd1;
        if (w_err[i])                 r_err[i]  <= r_err[i] + 32'd1;
      end
    end
  end

  assign stat_hit  = r_hit;
  assign stat_miss = r_miss;
  assign stat_err  = r_err;
`else
  logic w_unused_stats;
  assign w_unused_stats = ^{w_hit, w_err, w_lookup};

  always_comb begin
    for (int i = 0; i < NUM_IFACE; i++) begin
      stat_hit[i]  = 32'd0;
      stat_miss[i] = 32'd0;
      stat_err[i]  = 32'd0;
    end
  end
`endif

endmodule

// File: tb/tb_header_match_dispatch.sv
// Directed bench for header_match_dispatch: lookup, protocol errors, FIFO backpressure, arbitration.
module tb_header_match_dispatch;

  logic        clock = 1'b0;
  logic        reset;
  logic [73:0] pkt_data [3:0];
  logic [3:0]  pkt_valid, pkt_sop, pkt_eop, pkt_ready;
  logic [13:0] match_data;
  logic        match_valid, match_ready;
  logic        cfg_wr, cfg_en;
  logic [2:0]  cfg_addr;
  logic [47:0] cfg_mac;
  logic [1:0]  cfg_port;
  logic [31:0] stat_hit [3:0];
  logic [31:0] stat_miss [3:0];
  logic [31:0] stat_err [3:0];

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef HDR_MATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [47:0] MAC_A = 48'h001122334455;
  localparam logic [47:0] MAC_B = 48'hDEADBEEF0001;
  localparam logic [47:0] MAC_C = 48'h0A0B0C0D0E0F;

  header_match_dispatch dut (
    .clock(clock), .reset(reset),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_ready(pkt_ready),
    .match_data(match_data), .match_valid(match_valid), .match_ready(match_ready),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_mac(cfg_mac), .cfg_port(cfg_port),
    .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_err(stat_err)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    pkt_valid = 4'h0; pkt_sop = 4'h0; pkt_eop = 4'h0;
    for (int i = 0; i < 4; i++) pkt_data[i] = 74'd0;
    cfg_wr = 1'b0; cfg_en = 1'b0; cfg_addr = 3'd0; cfg_mac = 48'd0; cfg_port = 2'd0;
  endtask

  task automatic do_reset;
    clear_inputs();
    match_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic beat(input int i, input logic sop, input logic eop,
                      input logic [9:0] tag, input logic [47:0] mac);
    pkt_data[i] = {tag, mac, 16'h0800};
    pkt_valid[i] = 1'b1; pkt_sop[i] = sop; pkt_eop[i] = eop;
    tick();
    pkt_valid[i] = 1'b0; pkt_sop[i] = 1'b0; pkt_eop[i] = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic en, input logic [47:0] mac, input logic [1:0] p);
    cfg_wr = 1'b1; cfg_addr = a; cfg_en = en; cfg_mac = mac; cfg_port = p;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic pop_one;
    match_ready = 1'b1;
    tick();
    match_ready = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tick();
    vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", match_valid); end
    vec_cnt++; if (pkt_ready !== 4'hF) begin err_cnt++; $display("FAIL reset_ready: got %h want f", pkt_ready); end
    vec_cnt++; if ((stat_hit[0] | stat_miss[3] | stat_err[2]) !== 32'd0) begin err_cnt++; $display("FAIL reset_stats: got nonzero want 0"); end
  endtask

  task automatic test_hit;
    do_reset();
    cfg_write(3'd3, 1'b1, MAC_A, 2'd2);
    beat(1, 1'b1, 1'b0, 10'h007, MAC_A);
    beat(1, 1'b0, 1'b0, 10'h007, 48'd0);
    beat(1, 1'b0, 1'b0, 10'h007, 48'd0);
    vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL hit_early: got %b want 0", match_valid); end
    beat(1, 1'b0, 1'b1, 10'h007, 48'd0);
    vec_cnt++; if (match_valid !== 1'b1) begin err_cnt++; $display("FAIL hit_valid: got %b want 1", match_valid); end
    vec_cnt++; if (match_data !== 14'h2407) begin err_cnt++; $display("FAIL hit_data: got %h want 2407", match_data); end
    vec_cnt++; if (stat_hit[1] !== (STATS ? 32'd1 : 32'd0)) begin err_cnt++; $display("FAIL hit_stat: got %0d want %0d", stat_hit[1], STATS); end
    pop_one();
    vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL hit_drain: got %b want 0", match_valid); end
  endtask

  task automatic test_priority_and_write;
    do_reset();
    cfg_write(3'd1, 1'b1, MAC_C, 2'd3);
    cfg_write(3'd5, 1'b1, MAC_C, 2'd1);
    beat(2, 1'b1, 1'b1, 10'h055, MAC_C);
    vec_cnt++; if (match_data !== 14'h3855) begin err_cnt++; $display("FAIL prio_data: got %h want 3855", match_data); end
    pop_one();
    // disable entry 1 on the same edge as a lookup: the lookup still sees it
    cfg_wr = 1'b1; cfg_addr = 3'd1; cfg_en = 1'b0; cfg_mac = MAC_C; cfg_port = 2'd3;
    beat(2, 1'b1, 1'b1, 10'h056, MAC_C);
    cfg_wr = 1'b0;
    vec_cnt++; if (match_data !== 14'h3856) begin err_cnt++; $display("FAIL samecyc_data: got %h want 3856", match_data); end
    pop_one();
    beat(2, 1'b1, 1'b1, 10'h057, MAC_C);
    vec_cnt++; if (match_data !== 14'h1857) begin err_cnt++; $display("FAIL after_wr_data: got %h want 1857", match_data); end
    pop_one();
  endtask

  task automatic test_miss;
    do_reset();
    beat(0, 1'b1, 1'b1, 10'h3FF, MAC_B);
    vec_cnt++; if (match_data !== 14'h03FF || match_valid !== 1'b1) begin err_cnt++; $display("FAIL miss_data: got %h/%b want 03ff/1", match_data, match_valid); end
    vec_cnt++; if (stat_miss[0] !== (STATS ? 32'd1 : 32'd0)) begin err_cnt++; $display("FAIL miss_stat: got %0d want %0d", stat_miss[0], STATS); end
    vec_cnt++; if (stat_hit[0] !== 32'd0) begin err_cnt++; $display("FAIL miss_hitstat: got %0d want 0", stat_hit[0]); end
    pop_one();
  endtask

  task automatic test_round_robin;
    logic [13:0] exp_rr [4];
    exp_rr[0] = 14'h0010; exp_rr[1] = 14'h0411; exp_rr[2] = 14'h0812; exp_rr[3] = 14'h0C13;
    do_reset();
    match_ready = 1'b1;
    for (int i = 0; i < 4; i++) pkt_data[i] = {10'h010 + 10'(i), MAC_B, 16'h0};
    pkt_valid = 4'hF; pkt_sop = 4'hF; pkt_eop = 4'hF;
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      vec_cnt++; if (match_valid !== 1'b1 || match_data !== exp_rr[k]) begin err_cnt++; $display("FAIL rr_seq%0d: got %h/%b want %h/1", k, match_data, match_valid, exp_rr[k]); end
      tick();
    end
    vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL rr_empty: got %b want 0", match_valid); end
    // pointer back at 0: iface 0 beats iface 3 when both arrive together
    match_ready = 1'b0;
    pkt_data[0] = {10'h021, MAC_B, 16'h0}; pkt_data[3] = {10'h020, MAC_B, 16'h0};
    pkt_valid = 4'h9; pkt_sop = 4'h9; pkt_eop = 4'h9;
    tick();
    clear_inputs();
    vec_cnt++; if (match_data !== 14'h0021) begin err_cnt++; $display("FAIL rr_ptr0: got %h want 0021", match_data); end
    pop_one();
    vec_cnt++; if (match_data !== 14'h0C20) begin err_cnt++; $display("FAIL rr_next: got %h want 0c20", match_data); end
    pop_one();
  endtask

  task automatic test_grant_lock;
    do_reset();
    beat(2, 1'b1, 1'b1, 10'h022, MAC_B);
    tick();
    beat(0, 1'b1, 1'b1, 10'h001, MAC_B);
    vec_cnt++; if (match_data !== 14'h0822) begin err_cnt++; $display("FAIL lock_hold1: got %h want 0822", match_data); end
    tick();
    vec_cnt++; if (match_data !== 14'h0822) begin err_cnt++; $display("FAIL lock_hold2: got %h want 0822", match_data); end
    pop_one();
    vec_cnt++; if (match_valid !== 1'b1 || match_data !== 14'h0001) begin err_cnt++; $display("FAIL lock_next: got %h/%b want 0001/1", match_data, match_valid); end
    pop_one();
    vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL lock_empty: got %b want 0", match_valid); end
  endtask

  task automatic test_backpressure;
    logic [13:0] exp_q [4];
    exp_q[0] = 14'h0C30; exp_q[1] = 14'h0C31; exp_q[2] = 14'h0C32; exp_q[3] = 14'h0C33;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      vec_cnt++; if (pkt_ready[3] !== 1'b1) begin err_cnt++; $display("FAIL bp_ready_pre%0d: got %b want 1", n, pkt_ready[3]); end
      beat(3, 1'b1, 1'b1, 10'h030 + 10'(n), MAC_B);
    end
    vec_cnt++; if (pkt_ready[3] !== 1'b0) begin err_cnt++; $display("FAIL bp_full: got %b want 0", pkt_ready[3]); end
    beat(3, 1'b1, 1'b1, 10'h03F, MAC_B);
    vec_cnt++; if (match_data !== exp_q[0]) begin err_cnt++; $display("FAIL bp_head: got %h want %h", match_data, exp_q[0]); end
    pop_one();
    vec_cnt++; if (pkt_ready[3] !== 1'b1) begin err_cnt++; $display("FAIL bp_reopen: got %b want 1", pkt_ready[3]); end
    for (int n = 1; n < 4; n++) begin
      vec_cnt++; if (match_valid !== 1'b1 || match_data !== exp_q[n]) begin err_cnt++; $display("FAIL bp_drain%0d: got %h/%b want %h/1", n, match_data, match_valid, exp_q[n]); end
      pop_one();
    end
    vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_extra: got %b want 0", match_valid); end
  endtask

  task automatic test_protocol_errors;
    do_reset();
    cfg_write(3'd0, 1'b1, MAC_A, 2'd1);
    beat(0, 1'b0, 1'b1, 10'h001, MAC_A);
    beat(0, 1'b1, 1'b0, 10'h002, MAC_B);
    beat(0, 1'b1, 1'b0, 10'h003, MAC_A);
    vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL err_nopush: got %b want 0", match_valid); end
    beat(0, 1'b0, 1'b1, 10'h005, 48'd0);
    vec_cnt++; if (match_valid !== 1'b1 || match_data !== 14'h1005) begin err_cnt++; $display("FAIL err_data: got %h/%b want 1005/1", match_data, match_valid); end
    vec_cnt++; if (stat_err[0] !== (STATS ? 32'd2 : 32'd0)) begin err_cnt++; $display("FAIL err_stat: got %0d want %0d", stat_err[0], STATS ? 2 : 0); end
    pop_one();
    vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL err_single: got %b want 0", match_valid); end
  endtask

  task automatic test_reset_midpacket;
    do_reset();
    cfg_write(3'd0, 1'b1, MAC_A, 2'd2);
    beat(1, 1'b1, 1'b0, 10'h008, MAC_A);
    beat(0, 1'b1, 1'b1, 10'h003, MAC_B);
    do_reset();
    vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_flush: got %b want 0", match_valid); end
    beat(1, 1'b0, 1'b1, 10'h009, 48'd0);
    vec_cnt++; if (match_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_partial: got %b want 0", match_valid); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_priority_and_write();
    test_miss();
    test_round_robin();
    test_grant_lock();
    test_backpressure();
    test_protocol_errors();
    test_reset_midpacket();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
